// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor queue: descriptor layout and queue FSM states.
package dma_pkg;

  typedef logic [31:0] desc_addr_t;
  typedef logic [31:0] desc_num_t;

  typedef struct packed {
    desc_addr_t src;
    desc_addr_t dst;
    desc_num_t  len;
    logic       last;
  } desc_t;

  typedef enum logic [1:0] {
    DQ_IDLE  = 2'd0,
    DQ_ISSUE = 2'd1,
    DQ_BUSY  = 2'd2
  } dq_state_e;

endpackage : dma_pkg

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with first-word fall-through read and a flush that
// lets a same-cycle write land as the first entry of the emptied queue.
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en_i,
  input  desc_t                      wr_data_i,
  input  logic                       rd_en_i,
  input  logic                       flush_i,
  output desc_t                      rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  desc_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  logic [PW-1:0] wr_addr;
  logic          wr_fire;
  logic          rd_fire;

  // A write is taken when there is room, when a pop frees the head slot, or when a flush empties the queue.
  assign wr_fire = wr_en_i && (flush_i || !full_q || rd_en_i);
  assign rd_fire = rd_en_i && (count_q != '0) && !flush_i;
  assign wr_addr = flush_i ? '0 : wr_ptr_q;

  // Next-state pointers and occupancy; a flush resets both pointers before the optional write.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = wr_fire ? PW'(1) : '0;
      count_d  = wr_fire ? CW'(1) : '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(rd_fire);
      wr_ptr_d = wr_ptr_q + PW'(wr_fire);
      count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
    end
  end

  // Pointer, count and registered-full state.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

  // Descriptor storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only observed after it has been written.
    if (wr_fire) mem_q[wr_addr] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule : dma_desc_fifo

// File: rtl/dma_desc_queue.sv
// DMA descriptor queue: buffers CSR-pushed descriptors, issues them one at a time to the
// transfer engine, tracks the in-flight transfer and reports irq/error/overflow status.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int LW    = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          push_last_i,
  input  logic          clear_irq_i,
  input  logic [AW-1:0] push_src_i,
  input  logic [AW-1:0] push_dst_i,
  input  logic [LW-1:0] push_len_i,
  output logic          fifo_full_o,
  output logic          desc_valid_o,
  input  logic          desc_ready_i,
  output logic [AW-1:0] desc_src_o,
  output logic [AW-1:0] desc_dst_o,
  output logic [LW-1:0] desc_len_o,
  input  logic          xfer_done_i,
  input  logic          xfer_err_i,
  input  logic [AW-1:0] err_addr_i,
  output logic          irq_o,
  output logic          err_o,
  output logic [AW-1:0] err_addr_o,
  output logic          ovf_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  dq_state_e     state_q, state_d;
  logic          last_q;
  logic          irq_q, irq_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] err_addr_q;

  desc_t         push_desc;
  desc_t         head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic          err_ev;
  logic          done_ev;

  assign push_desc = '{src: push_src_i, dst: push_dst_i, len: push_len_i, last: push_last_i};
  assign pop       = (state_q == DQ_ISSUE) && desc_ready_i;
  assign err_ev    = (state_q == DQ_BUSY) && xfer_err_i;
  assign done_ev   = (state_q == DQ_BUSY) && xfer_done_i && !xfer_err_i;

  dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (push_i),
    .wr_data_i (push_desc),
    .rd_en_i   (pop),
    .flush_i   (err_ev),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Issue FSM: wait for a queued entry, offer it, then wait for the engine to finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DQ_IDLE:  if (!fifo_empty) state_d = DQ_ISSUE;
      DQ_ISSUE: if (desc_ready_i) state_d = DQ_BUSY;
      DQ_BUSY:  if (xfer_err_i || xfer_done_i) state_d = DQ_IDLE;
      default:  state_d = DQ_IDLE;
    endcase
  end

  // Sticky status flags: a set in the same cycle as a clear wins.
  always_comb begin
    irq_d = irq_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clear_irq_i) begin
      irq_d = 1'b0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (done_ev && last_q) irq_d = 1'b1;
    if (err_ev) err_d = 1'b1;
    // A push is lost only when the queue is full and neither a pop nor a flush makes room.
    if (push_i && (fifo_count == CW'(DEPTH)) && !pop && !err_ev) ovf_d = 1'b1;
  end

  // FSM, in-flight last tag, status flags and captured error address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= DQ_IDLE;
      last_q     <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      if (pop)    last_q     <= head.last;
      if (err_ev) err_addr_q <= err_addr_i;
    end
  end

  // The descriptor bus reads as zero whenever nothing is being offered.
  assign desc_valid_o = (state_q == DQ_ISSUE);
  assign desc_src_o   = desc_valid_o ? head.src : '0;
  assign desc_dst_o   = desc_valid_o ? head.dst : '0;
  assign desc_len_o   = desc_valid_o ? head.len : '0;
  assign fifo_full_o  = fifo_full;
  assign irq_o        = irq_q;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;
  assign ovf_o        = ovf_q;

endmodule : dma_desc_queue
